// File: rtl/joint_stepper_timed.sv
// Step/direction pulse generator for one joint: signed period command in, STP/DIR out,
// signed step-count feedback. STP high time is fixed and DIR is held stable ahead of a step.
//
// state   | meaning
// IDLE    | stopped, STP low, period counter cleared
// RUN     | counting the step period, fires STP when the period elapses
// PULSE   | STP held high for PULSE_LEN cycles, never cut short
// DIRWAIT | DIR just toggled, waiting DIR_SETUP cycles before stepping resumes
module joint_stepper_timed #(
    parameter int WIDTH     = 32,
    parameter int PULSE_LEN = 16,
    parameter int DIR_SETUP = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    jointEnable,
    input  logic signed [WIDTH-1:0] jointFreqCmd,
    output logic signed [WIDTH-1:0] jointFeedback,
    output logic                    DIR,
    output logic                    STP
);

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2 * PULSE_LEN);
    localparam logic [WIDTH-1:0] SETUP_TC   = WIDTH'(DIR_SETUP - 1);
    localparam logic [PW-1:0]    PULSE_TC   = PW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PULSE   = 2'd2,
        DIRWAIT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic                    stp_q, stp_d;
    logic                    dir_q, dir_d;
    logic signed [WIDTH-1:0] fb_q, fb_d;

    logic                    req_dir;
    logic                    go;
    logic [WIDTH-1:0]        cmd_abs;
    logic [WIDTH-1:0]        eff_period;
    logic [WIDTH-1:0]        period_tc;
    logic                    step_due;

    // Negating the most negative command wraps to 2^(WIDTH-1), which is the
    // correct magnitude once the result is read as unsigned.
    assign req_dir    = !jointFreqCmd[WIDTH-1] && (jointFreqCmd != '0);
    assign cmd_abs    = jointFreqCmd[WIDTH-1] ? $unsigned(-jointFreqCmd) : $unsigned(jointFreqCmd);
    assign eff_period = (cmd_abs > MIN_PERIOD) ? cmd_abs : MIN_PERIOD;
    assign period_tc  = eff_period - WIDTH'(1);
    assign step_due   = (cnt_q >= period_tc);
    assign go         = jointEnable && (jointFreqCmd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            stp_q   <= 1'b0;
            dir_q   <= 1'b0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            stp_q   <= stp_d;
            dir_q   <= dir_d;
            fb_q    <= fb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + WIDTH'(1);
        pcnt_d  = pcnt_q;
        stp_d   = stp_q;
        dir_d   = dir_q;
        fb_d    = fb_q;

        case (state_q)
            IDLE: begin
                stp_d = 1'b0;
                cnt_d = '0;
                if (go) begin
                    if (req_dir == dir_q) begin
                        state_d = RUN;
                    end else begin
                        dir_d   = ~dir_q;
                        state_d = DIRWAIT;
                    end
                end
            end

            RUN: begin
                if (!go) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (req_dir != dir_q) begin
                    dir_d   = ~dir_q;
                    cnt_d   = '0;
                    state_d = DIRWAIT;
                end else if (step_due) begin
                    stp_d   = 1'b1;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                    fb_d    = dir_q ? (fb_q + WIDTH'(1)) : (fb_q - WIDTH'(1));
                    state_d = PULSE;
                end
            end

            // cnt keeps running through the pulse so the period is rising-to-rising.
            PULSE: begin
                pcnt_d = pcnt_q + PW'(1);
                if (pcnt_q == PULSE_TC) begin
                    stp_d   = 1'b0;
                    state_d = RUN;
                end
            end

            DIRWAIT: begin
                stp_d = 1'b0;
                if (!go) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (req_dir != dir_q) begin
                    dir_d = ~dir_q;
                    cnt_d = '0;
                end else if (cnt_q == SETUP_TC) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                stp_d   = 1'b0;
            end
        endcase
    end

    assign STP           = stp_q;
    assign DIR           = dir_q;
    assign jointFeedback = fb_q;

endmodule

// File: tb/tb_joint_stepper_timed.sv
// Directed bench for joint_stepper_timed: a 32-bit instance (PULSE_LEN=4, DIR_SETUP=8)
// for timing/reversal/reset behaviour and an 8-bit instance for feedback wrap.
module tb_joint_stepper_timed;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic signed [31:0] cmd;
    logic signed [31:0] fb;
    logic               dir;
    logic               stp;

    logic               en8;
    logic signed [7:0]  cmd8;
    logic signed [7:0]  fb8;
    logic               dir8;
    logic               stp8;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    joint_stepper_timed #(.WIDTH(32), .PULSE_LEN(4), .DIR_SETUP(8)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jointEnable   (en),
        .jointFreqCmd  (cmd),
        .jointFeedback (fb),
        .DIR           (dir),
        .STP           (stp)
    );

    joint_stepper_timed #(.WIDTH(8), .PULSE_LEN(4), .DIR_SETUP(8)) u_dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .jointEnable   (en8),
        .jointFreqCmd  (cmd8),
        .jointFeedback (fb8),
        .DIR           (dir8),
        .STP           (stp8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return stp;
            1:       return dir;
            2:       return stp8;
            default: return dir8;
        endcase
    endfunction

    // Called on a negedge; returns the cycle number at which the signal first reads val.
    task automatic wait_sig(input int sel, input logic val, input int limit, input string tag,
                            output int at);
        int n;
        n = 0;
        while (get_sig(sel) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(get_sig(sel)), 32'(val));
        at = cyc;
    endtask

    task automatic count_high(input int ncyc, output int hi);
        hi = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (stp) hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, t3, hi, c0;
        rst_n = 1'b0;
        en    = 1'b0;
        cmd   = '0;
        en8   = 1'b0;
        cmd8  = '0;

        repeat (3) @(negedge clk);
        check("rst_stp", 32'(stp), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_fb", fb, 0);
        rst_n = 1'b1;

        // +10 from reset: DIR rises, then setup (8) + period (10) to the first step
        @(negedge clk);
        en  = 1'b1;
        cmd = 32'sd10;
        wait_sig(1, 1'b1, 20, "dir_up", t0);
        wait_sig(0, 1'b1, 40, "rise", t1);
        check("first_rise_after_dir", t1 - t0, 18);
        check("fb_first", fb, 1);
        wait_sig(0, 1'b0, 20, "fall", t2);
        check("high_p10", t2 - t1, 4);
        wait_sig(0, 1'b1, 20, "rise", t3);
        check("low_p10", t3 - t2, 6);
        check("period_p10", t3 - t1, 10);
        repeat (3) begin
            wait_sig(0, 1'b0, 20, "fall", t2);
            wait_sig(0, 1'b1, 20, "rise", t3);
        end
        check("fb_after5", fb, 5);

        // +3 is clamped to 2*PULSE_LEN = 8
        cmd = 32'sd3;
        t1  = t3;
        wait_sig(0, 1'b0, 20, "fall", t2);
        wait_sig(0, 1'b1, 20, "rise", t3);
        check("clamp_first", t3 - t1, 8);
        wait_sig(0, 1'b0, 20, "fall", t2);
        check("high_clamp", t2 - t3, 4);
        t1 = t3;
        wait_sig(0, 1'b1, 20, "rise", t3);
        check("low_clamp", t3 - t2, 4);
        check("fb_clamp", fb, 7);

        // back to +10, then reverse to -10 mid-pulse
        cmd = 32'sd10;
        t1  = t3;
        wait_sig(0, 1'b0, 20, "fall", t2);
        wait_sig(0, 1'b1, 20, "rise", t3);
        check("p10_resume", t3 - t1, 10);
        check("fb_p10", fb, 8);
        cmd = -32'sd10;
        t1  = t3;
        wait_sig(0, 1'b0, 20, "fall", t2);
        check("rev_pulse_high", t2 - t1, 4);
        wait_sig(1, 1'b0, 20, "dir_down", t0);
        check("dir_after_fall", t0 - t2, 1);
        wait_sig(0, 1'b1, 40, "rise", t3);
        check("rev_rise", t3 - t0, 18);
        check("fb_rev", fb, 7);

        // disable in the first pulse cycle: pulse completes, then idle
        en = 1'b0;
        t1 = t3;
        wait_sig(0, 1'b0, 20, "fall", t2);
        check("dis_pulse_high", t2 - t1, 4);
        count_high(30, hi);
        check("stp_off", hi, 0);
        check("fb_hold", fb, 7);
        en = 1'b1;
        c0 = cyc;
        wait_sig(0, 1'b1, 30, "rise", t3);
        check("reenable_rise", t3 - c0, 11);
        check("fb_reen", fb, 6);

        // -3 from IDLE with DIR already 0: no setup wait, period 8, feedback decrements
        en = 1'b0;
        wait_sig(0, 1'b0, 20, "fall", t2);
        repeat (5) @(negedge clk);
        cmd = -32'sd3;
        en  = 1'b1;
        c0  = cyc;
        wait_sig(0, 1'b1, 30, "rise", t3);
        check("dir_hold0", 32'(dir), 0);
        check("neg3_first", t3 - c0, 9);
        check("fb_neg1", fb, 5);
        t1 = t3;
        wait_sig(0, 1'b0, 20, "fall", t2);
        wait_sig(0, 1'b1, 20, "rise", t3);
        check("neg3_period", t3 - t1, 8);
        check("fb_neg2", fb, 4);

        // most negative command: magnitude 2^31, no step in any reachable time
        wait_sig(0, 1'b0, 20, "fall", t2);
        cmd = 32'sh8000_0000;
        count_high(300, hi);
        check("minneg_no_step", hi, 0);
        check("minneg_dir", 32'(dir), 0);
        check("minneg_fb", fb, 4);

        // async reset mid-DIRWAIT
        cmd = 32'sd10;
        wait_sig(1, 1'b1, 20, "dir_up", t0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstdw_stp", 32'(stp), 0);
        check("rstdw_dir", 32'(dir), 0);
        check("rstdw_fb", fb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sig(1, 1'b1, 20, "dir_up", t0);
        wait_sig(0, 1'b1, 40, "rise", t3);
        check("rstdw_restart", t3 - t0, 18);
        check("rstdw_fb1", fb, 1);

        // async reset mid-pulse
        #2 rst_n = 1'b0;
        #1;
        check("rstp_stp", 32'(stp), 0);
        check("rstp_dir", 32'(dir), 0);
        check("rstp_fb", fb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sig(1, 1'b1, 20, "dir_up", t0);
        wait_sig(0, 1'b1, 40, "rise", t3);
        check("rstp_restart", t3 - t0, 18);
        check("rstp_fb1", fb, 1);
        en = 1'b0;

        // 8-bit instance: feedback wraps 127 -> -128, and cmd 0x80 means period 128
        @(negedge clk);
        en8  = 1'b1;
        cmd8 = 8'sd8;
        wait_sig(3, 1'b1, 20, "dir8_up", t0);
        for (int i = 0; i < 127; i++) begin
            wait_sig(2, 1'b0, 30, "fall8", t2);
            wait_sig(2, 1'b1, 30, "rise8", t3);
        end
        check("fb8_127", {24'b0, fb8}, 32'h7F);
        wait_sig(2, 1'b0, 30, "fall8", t2);
        wait_sig(2, 1'b1, 30, "rise8", t1);
        check("fb8_wrap", {24'b0, fb8}, 32'h80);
        cmd8 = 8'sh80;
        wait_sig(3, 1'b0, 20, "dir8_down", t0);
        check("dir8_after_rise", t0 - t1, 5);
        wait_sig(2, 1'b1, 200, "rise8", t3);
        check("minneg8_rise", t3 - t0, 136);
        check("fb8_wrap_down", {24'b0, fb8}, 32'h7F);
        en8 = 1'b0;

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
